// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width/limit, ramp FSM encoding, period helper.
package pwm_pkg;

  localparam int unsigned C_DUTY_W   = 8;
  localparam int unsigned C_DUTY_MAX = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } ramp_state_t;

  // Latched ramp command: target duty and step size, both in percent.
  typedef struct packed {
    logic [C_DUTY_W-1:0] target;
    logic [C_DUTY_W-1:0] step;
  } ramp_cmd_t;

  // PWM period length in system clocks.
  function automatic int unsigned f_timerlim(input int unsigned clkfreq,
                                             input int unsigned pwmfreq);
    return clkfreq / pwmfreq;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command port of the ramp controller: valid/ready with target duty and step.
interface pwm_ramp_ctrl_if
  import pwm_pkg::*;
();

  logic                cmd_valid;
  logic                cmd_ready;
  logic [C_DUTY_W-1:0] cmd_duty;
  logic [C_DUTY_W-1:0] cmd_step;

  modport master (
    output cmd_valid,
    output cmd_duty,
    output cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_duty,
    input  cmd_step,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_tick_gen.sv
// Free-running PWM period counter plus hold counter that paces ramp steps.
module pwm_tick_gen #(
  parameter int unsigned c_period = 10,
  parameter int unsigned c_hold   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic period_o,
  output logic step_tick
);

  localparam int unsigned CNT_W  = (c_period > 1) ? $clog2(c_period) : 1;
  localparam int unsigned HOLD_W = (c_hold > 1) ? $clog2(c_hold) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(c_period - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(c_hold - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Next counter values; pulses are registered from these so they line up with the count.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    hold_d = hold_q;
    if (clr) begin
      hold_d = '0;
    end else if (period_o) begin
      hold_d = (hold_q == HOLD_LAST) ? '0 : hold_q + HOLD_W'(1);
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      hold_q    <= '0;
      period_o  <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      period_o  <= (cnt_d == CNT_LAST);
      step_tick <= (cnt_d == CNT_LAST) && (hold_d == HOLD_LAST);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: slews the live PWM duty toward a commanded target.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned c_clkfreq = 100_000_000,
  parameter int unsigned c_pwmfreq = 10000,
  parameter int unsigned c_hold    = 4
) (
  input  logic                clk,
  input  logic                rst,
  pwm_ramp_ctrl_if.slave      cmd,
  input  logic                estop,
  output logic [C_DUTY_W-1:0] duty_o,
  output logic                busy,
  output logic                done,
  output logic                period_o
);

  localparam int unsigned C_PERIOD = f_timerlim(c_clkfreq, c_pwmfreq);
  localparam logic [C_DUTY_W-1:0] DUTY_MAX = C_DUTY_W'(C_DUTY_MAX);

  ramp_state_t         state_q, state_d;
  ramp_cmd_t           cmd_q, cmd_d, cmd_in;
  logic [C_DUTY_W-1:0] duty_d, diff;
  logic                busy_d, done_d, ready_q;
  logic                accept, step_tick;

  // Commands are only taken in IDLE, never the cycle out of reset, never under estop.
  assign cmd.cmd_ready = ready_q && (state_q == ST_IDLE) && !estop;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Clamp target to full scale and promote a zero step to one.
  always_comb begin
    cmd_in.target = (cmd.cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd.cmd_duty;
    cmd_in.step   = (cmd.cmd_step == '0) ? C_DUTY_W'(1) : cmd.cmd_step;
  end

  // Distance to target, compared first so the subtraction never wraps.
  assign diff = (cmd_q.target > duty_o) ? (cmd_q.target - duty_o) : (duty_o - cmd_q.target);

  pwm_tick_gen #(
    .c_period (C_PERIOD),
    .c_hold   (c_hold)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .period_o  (period_o),
    .step_tick (step_tick)
  );

  // Next state, duty and done; estop overrides everything below reset.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    duty_d  = duty_o;
    done_d  = 1'b0;
    if (estop) begin
      state_d = ST_IDLE;
      duty_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_d = cmd_in;
            if (cmd_in.target == duty_o) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RAMP;
            end
          end
        end
        ST_RAMP: begin
          if (step_tick) begin
            if (diff <= cmd_q.step) begin
              duty_d  = cmd_q.target;
              state_d = ST_DONE;
            end else if (cmd_q.target > duty_o) begin
              duty_d = duty_o + cmd_q.step;
            end else begin
              duty_d = duty_o - cmd_q.step;
            end
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RAMP) || (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      duty_o  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      duty_o  <= duty_d;
      busy    <= busy_d;
      done    <= done_d;
      ready_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl with P=10 clocks per PWM period and c_hold=2.
module tb_pwm_ramp_ctrl;

  localparam int P    = 10;
  localparam int HOLD = 2;
  localparam int GAP  = P * HOLD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       estop = 1'b0;
  logic [7:0] duty_o;
  logic       busy, done, period_o;

  pwm_ramp_ctrl_if cmd_if ();

  pwm_ramp_ctrl #(
    .c_clkfreq (1000),
    .c_pwmfreq (100),
    .c_hold    (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if.slave),
    .estop    (estop),
    .duty_o   (duty_o),
    .busy     (busy),
    .done     (done),
    .period_o (period_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int mdl_duty = 0;
  int last_cyc = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected duty trajectory of one command, pushed when the command is driven.
  task automatic push_ramp(input int duty, input int step);
    int tgt, stp;
    tgt = (duty > 100) ? 100 : duty;
    stp = (step == 0) ? 1 : step;
    while (mdl_duty != tgt) begin
      if (((tgt > mdl_duty) ? tgt - mdl_duty : mdl_duty - tgt) <= stp) mdl_duty = tgt;
      else if (tgt > mdl_duty) mdl_duty = mdl_duty + stp;
      else mdl_duty = mdl_duty - stp;
      exp_q.push_back(mdl_duty);
    end
  endtask

  // Drive one command and hold it until the controller takes it.
  task automatic send(input int duty, input int step);
    bit ok = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_duty  = 8'(duty);
    cmd_if.cmd_step  = 8'(step);
    for (int i = 0; i < 60; i++) begin
      if (cmd_if.cmd_ready) begin
        ok = 1;
        last_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    else push_ramp(duty, step);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Pop and compare n duty updates; first_after_accept selects the latency window.
  task automatic watch_steps(input int n, input bit first_after_accept);
    int prev, gap, exp;
    bit seen;
    for (int k = 0; k < n; k++) begin
      prev = int'(duty_o);
      seen = 0;
      for (int i = 0; i < GAP + 4; i++) begin
        if (int'(duty_o) != prev) begin
          seen = 1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) begin
        check("step_timeout", 0, 1);
        return;
      end
      exp = exp_q.pop_front();
      gap = cyc - last_cyc;
      check("duty_step", int'(duty_o), exp);
      check("busy_in_ramp", int'(busy), 1);
      if (k == 0 && first_after_accept)
        check("first_step_window", int'(gap >= GAP - P + 2 && gap <= GAP + 1), 1);
      else
        check("step_gap", gap, GAP);
      last_cyc = cyc;
    end
  endtask

  task automatic finish_ramp();
    check("done_before", int'(done), 0);
    @(negedge clk);
    check("done_pulse", int'(done), 1);
    check("busy_fall", int'(busy), 0);
    @(negedge clk);
    check("done_width", int'(done), 0);
  endtask

  // Returns the cycle of the next period_o pulse after the current one.
  task automatic next_period(output int at);
    at = -1;
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      if (period_o) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("period_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_duty"}, int'(duty_o), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_ready"}, int'(cmd_if.cmd_ready), 0);
    check({tag, "_period"}, int'(period_o), 0);
  endtask

  initial begin
    int c0, t1, t2;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_duty  = '0;
    cmd_if.cmd_step  = '0;

    // Reset, ready one clock after release, period spacing
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    c0 = cyc;
    @(negedge clk);
    check("ready_after_rst", int'(cmd_if.cmd_ready), 1);
    next_period(t1);
    check("first_period", t1 - c0, P - 1);
    next_period(t2);
    check("period_len", t2 - t1, P);

    // Ramp up 0 -> 50 by 20
    send(50, 20);
    check("busy_after_accept", int'(busy), 1);
    watch_steps(3, 1);
    finish_ramp();

    // Clamp and zero step: 50 -> 100 by 1, then down by 30
    send(200, 0);
    watch_steps(50, 1);
    finish_ramp();
    send(0, 30);
    watch_steps(4, 1);
    finish_ramp();

    // estop mid-ramp with a command held during estop
    send(100, 10);
    watch_steps(3, 1);
    check("estop_at", int'(duty_o), 30);
    estop = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_duty  = 8'd60;
    cmd_if.cmd_step  = 8'd5;
    check("estop_ready", int'(cmd_if.cmd_ready), 0);
    @(negedge clk);
    check("estop_duty", int'(duty_o), 0);
    check("estop_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      check("estop_no_done", int'(done), 0);
      check("estop_hold_ready", int'(cmd_if.cmd_ready), 0);
      @(negedge clk);
    end
    estop = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    exp_q.delete();
    mdl_duty = 0;
    repeat (3) @(negedge clk);
    check("estop_dropped_busy", int'(busy), 0);
    check("estop_dropped_duty", int'(duty_o), 0);
    check("estop_ready_back", int'(cmd_if.cmd_ready), 1);

    // Back-pressure during a ramp, then a no-op command
    send(40, 20);
    watch_steps(1, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_duty  = 8'd90;
    cmd_if.cmd_step  = 8'd50;
    for (int i = 0; i < 4; i++) begin
      check("ramp_backpressure", int'(cmd_if.cmd_ready), 0);
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    watch_steps(1, 0);
    finish_ramp();
    send(40, 5);
    check("noop_queue", exp_q.size(), 0);
    check("noop_done", int'(done), 1);
    check("noop_busy", int'(busy), 0);
    check("noop_duty", int'(duty_o), 40);
    @(negedge clk);
    check("noop_done_width", int'(done), 0);
    check("noop_busy_after", int'(busy), 0);

    // Reset mid-ramp at 40
    send(20, 20);
    watch_steps(1, 1);
    finish_ramp();
    send(100, 20);
    watch_steps(1, 1);
    check("rst_at", int'(duty_o), 40);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    mdl_duty = 0;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", int'(done), 0);
    end
    t1 = -1;
    for (int i = 0; i < 2 * P && t1 < 0; i++) begin
      if (period_o) t1 = cyc;
      else @(negedge clk);
    end
    check("midrst_period_restart", t1 - c0, P - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule
